// File: rtl/mem_loader.sv
// mem_loader
// Boot-time data-memory loader for the single-cycle RV32IM top level.
// Accepts a byte stream over a valid/ready handshake and packs the bytes
// little-endian into 32-bit words. Each word is written through the top
// level's external write port while the core is held in reset. After the
// last word the core is released.
//
// Optional feature: define LOADER_CHECKSUM_EN to require a trailing
// checksum byte. The 8-bit sum of all payload bytes plus this byte must
// equal zero, otherwise the loader parks in an error state.
//
// Parameters:
//   WORDS     number of 32-bit words per load (1..1024)
//   BASE_ADDR word-aligned byte address of the first word
//
// Ports:
//   clk           system clock, rising edge
//   reset         synchronous active-high reset
//   start         single-cycle pulse that begins a (re)load
//   in_valid      byte available on in_data
//   in_data       stream byte
//   in_ready      loader accepts a byte this cycle
//   Ext_MemWrite  external write strobe, high for one cycle per word
//   Ext_DataAdr   external write byte address
//   Ext_WriteData external write data word
//   cpu_reset     core reset, low only once the load has completed
//   busy          load in progress
//   done          load complete, core released
//   error         checksum failure (always 0 without LOADER_CHECKSUM_EN)
module mem_loader #(
  parameter int unsigned WORDS     = 64,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        Ext_MemWrite,
  output logic [31:0] Ext_DataAdr,
  output logic [31:0] Ext_WriteData,
  output logic        cpu_reset,
  output logic        busy,
  output logic        done,
  output logic        error
);

  localparam int IDXW = $clog2(WORDS + 1);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(WORDS - 1);

`ifdef LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {IDLE, COLLECT, WRITE, CHECK, RUN, ERR} state_t;
`else
  typedef enum logic [2:0] {IDLE, COLLECT, WRITE, RUN} state_t;
`endif

  state_t r_state;
  state_t w_nextState;

  logic [IDXW-1:0] r_wordIdx;
  logic [1:0]      r_byteIdx;
  logic [23:0]     r_word;
  logic [31:0]     r_adr;
  logic [31:0]     r_wdata;
  logic            w_accept;
  logic            w_collectAccept;
  logic            w_startLoad;
  logic            w_lastByte;
  logic            w_lastWord;

  assign w_accept        = in_valid && in_ready;
  assign w_collectAccept = w_accept && (r_state == COLLECT);
  assign w_lastByte      = (r_byteIdx == 2'd3);
  assign w_lastWord      = (r_wordIdx == LAST_IDX);

  // A load can be (re)started only from the resting states; start is
  // deliberately ignored while a load is in flight.
  always_comb begin
    w_startLoad = 1'b0;
    case (r_state)
      IDLE, RUN: w_startLoad = start;
`ifdef LOADER_CHECKSUM_EN
      ERR:       w_startLoad = start;
`endif
      default:   w_startLoad = 1'b0;
    endcase
  end

`ifdef LOADER_CHECKSUM_EN
  logic [7:0] r_sum;
  logic [7:0] w_sumNext;
  assign w_sumNext = r_sum + in_data;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic. WRITE always lasts one cycle; the final WRITE either
  // releases the core or, with the checksum enabled, waits for the check byte.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (start) w_nextState = COLLECT;
      COLLECT: if (w_accept && w_lastByte) w_nextState = WRITE;
      WRITE: begin
        if (w_lastWord) begin
`ifdef LOADER_CHECKSUM_EN
          w_nextState = CHECK;
`else
          w_nextState = RUN;
`endif
        end else begin
          w_nextState = COLLECT;
        end
      end
`ifdef LOADER_CHECKSUM_EN
      CHECK:   if (w_accept) w_nextState = (w_sumNext == 8'd0) ? RUN : ERR;
      ERR:     if (start) w_nextState = COLLECT;
`endif
      RUN:     if (start) w_nextState = COLLECT;
      default: w_nextState = IDLE;
    endcase
  end

  // Moore output decode; nothing here looks at the inputs.
  always_comb begin
    in_ready     = 1'b0;
    Ext_MemWrite = 1'b0;
    cpu_reset    = 1'b1;
    busy         = 1'b0;
    done         = 1'b0;
    error        = 1'b0;
    case (r_state)
      COLLECT: begin
        in_ready = 1'b1;
        busy     = 1'b1;
      end
      WRITE: begin
        Ext_MemWrite = 1'b1;
        busy         = 1'b1;
      end
`ifdef LOADER_CHECKSUM_EN
      CHECK: begin
        in_ready = 1'b1;
        busy     = 1'b1;
      end
      ERR:     error = 1'b1;
`endif
      RUN: begin
        cpu_reset = 1'b0;
        done      = 1'b1;
      end
      default: ;
    endcase
  end

  assign Ext_DataAdr   = r_adr;
  assign Ext_WriteData = r_wdata;

  // Datapath. The address/data registers are loaded on the edge that takes
  // the 4th byte, so they are already valid during the WRITE cycle and then
  // hold their value until the next word. Only the lower three bytes need
  // buffering; the 4th goes straight into the write-data register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wordIdx <= '0;
      r_byteIdx <= '0;
      r_word    <= '0;
      r_adr     <= '0;
      r_wdata   <= '0;
`ifdef LOADER_CHECKSUM_EN
      r_sum     <= '0;
`endif
    end else begin
      if (w_startLoad) begin
        r_wordIdx <= '0;
        r_byteIdx <= '0;
`ifdef LOADER_CHECKSUM_EN
        r_sum     <= '0;
`endif
      end
      if (w_collectAccept) begin
        r_byteIdx <= r_byteIdx + 2'd1;
`ifdef LOADER_CHECKSUM_EN
        r_sum     <= w_sumNext;
`endif
        case (r_byteIdx)
          2'd0: r_word[7:0]   <= in_data;
          2'd1: r_word[15:8]  <= in_data;
          2'd2: r_word[23:16] <= in_data;
          default: begin
            r_wdata <= {in_data, r_word};
            r_adr   <= BASE_ADDR + (32'(r_wordIdx) << 2);
          end
        endcase
      end
      if (r_state == WRITE) begin
        r_wordIdx <= r_wordIdx + IDXW'(1);
      end
    end
  end

endmodule

// File: tb/tb_mem_loader.sv
// tb_mem_loader
// Bench for mem_loader. Two instances share one stimulus stream: dutA with
// BASE_ADDR 0 and dutB with BASE_ADDR 0xFFFFFFFC, both WORDS=2, so address
// wrap is exercised on every load. With LOADER_CHECKSUM_EN a third WORDS=1
// instance covers the good/bad checksum paths.
module tb_mem_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        inValid;
  logic [7:0]  inData;

  logic        aReady, aMw, aCpuRst, aBusy, aDone, aErr;
  logic [31:0] aAdr, aWd;
  logic        bReady, bMw, bCpuRst, bBusy, bDone, bErr;
  logic [31:0] bAdr, bWd;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit monEn = 1'b0;

  always #5 clk = ~clk;

  // Edge counter used to verify write latency relative to byte acceptance.
  always @(posedge clk) cyc <= cyc + 1;

  mem_loader #(.WORDS(2), .BASE_ADDR(32'h0000_0000)) dutA (
    .clk(clk), .reset(reset), .start(start), .in_valid(inValid), .in_data(inData),
    .in_ready(aReady), .Ext_MemWrite(aMw), .Ext_DataAdr(aAdr), .Ext_WriteData(aWd),
    .cpu_reset(aCpuRst), .busy(aBusy), .done(aDone), .error(aErr)
  );

  mem_loader #(.WORDS(2), .BASE_ADDR(32'hFFFF_FFFC)) dutB (
    .clk(clk), .reset(reset), .start(start), .in_valid(inValid), .in_data(inData),
    .in_ready(bReady), .Ext_MemWrite(bMw), .Ext_DataAdr(bAdr), .Ext_WriteData(bWd),
    .cpu_reset(bCpuRst), .busy(bBusy), .done(bDone), .error(bErr)
  );

  task automatic checkOutput(input string name, input logic [191:0] act, input logic [191:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: bytes handed over by the driver, packed by plain
  // arithmetic into expected {address, word, cycle} write records.
  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    int          cyc;
  } wr_t;

  wr_t         expQ[$];
  int          mWord;
  int          mByte;
  logic [31:0] mAcc;
  logic [7:0]  mSum;
  logic [7:0]  sb[8];

  // Write monitor: every strobe must match the next expected record, on
  // both instances, in the cycle right after the 4th byte was accepted.
  always @(negedge clk) begin
    if (monEn && (aMw || bMw)) begin
      if (expQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpectedWrite: got adr %h data %h, no write expected", aAdr, aWd);
      end else begin
        wr_t e;
        e = expQ.pop_front();
        checkOutput("write", {aMw, bMw, aAdr, aWd, bAdr, bWd, 32'(cyc)},
                    {1'b1, 1'b1, e.addr, e.data, e.addr + 32'hFFFF_FFFC, e.data, 32'(e.cyc)});
      end
    end
  end

  // Present one byte after 'gap' idle cycles and hold it until accepted.
  task automatic applyStimulus(input logic [7:0] b, input int gap, input bit payload);
    int t;
    repeat (gap) begin @(posedge clk); #1; end
    inValid = 1'b1;
    inData  = b;
    t = 0;
    forever begin
      @(negedge clk);
      if (aReady) break;
      t++;
      if (t > 40) begin
        checks++;
        errors++;
        $display("[TB] FAIL acceptTimeout: byte %h not accepted within 40 cycles", b);
        inValid = 1'b0;
        return;
      end
    end
    if (payload) begin
      mAcc = mAcc | (32'(b) << (8 * mByte));
      mSum = mSum + b;
      mByte++;
      if (mByte == 4) begin
        expQ.push_back('{addr: 32'(4 * mWord), data: mAcc, cyc: cyc + 1});
        mWord++;
        mByte = 0;
        mAcc  = '0;
      end
    end
    @(posedge clk); #1;
    inValid = 1'b0;
  endtask

  task automatic doStart(input string name);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    mWord = 0; mByte = 0; mAcc = '0; mSum = '0;
    checkOutput(name, {aReady, aBusy, aCpuRst, aDone, bReady, bBusy, bCpuRst, bDone},
                {8'b1110_1110});
  endtask

  // gap < 0 selects a random 0..2 idle cycles before each byte.
  task automatic loadStream(input string name, input int gap);
    for (int i = 0; i < 8; i++) begin
      applyStimulus(sb[i], (gap < 0) ? int'($urandom_range(0, 2)) : gap, 1'b1);
    end
`ifdef LOADER_CHECKSUM_EN
    applyStimulus(8'(8'd0 - mSum), 0, 1'b0);
`else
    @(posedge clk); #1;
`endif
    checkOutput(name, {aDone, aCpuRst, aBusy, aErr, bDone, bCpuRst, bBusy, bErr, 32'(expQ.size())},
                {8'b1000_1000, 32'd0});
  endtask

  typedef struct {
    logic        st;
    logic        vld;
    logic [7:0]  dat;
    logic        rdy;
    logic        mw;
    logic [31:0] adrA;
    logic [31:0] adrB;
    logic [31:0] wd;
    logic        cr;
    logic        bz;
    logic        dn;
  } vec_t;

  function automatic vec_t mk(logic st, logic vld, logic [7:0] dat, logic rdy, logic mw,
                              logic [31:0] adrA, logic [31:0] adrB, logic [31:0] wd,
                              logic cr, logic bz, logic dn);
    vec_t v;
    v.st = st; v.vld = vld; v.dat = dat; v.rdy = rdy; v.mw = mw;
    v.adrA = adrA; v.adrB = adrB; v.wd = wd; v.cr = cr; v.bz = bz; v.dn = dn;
    return v;
  endfunction

`ifdef LOADER_CHECKSUM_EN
  logic        cStart, cValid;
  logic [7:0]  cData;
  logic        cReady, cMw, cCpuRst, cBusy, cDone, cErr;
  logic [31:0] cAdr, cWd;

  mem_loader #(.WORDS(1), .BASE_ADDR(32'h0000_0100)) dutC (
    .clk(clk), .reset(reset), .start(cStart), .in_valid(cValid), .in_data(cData),
    .in_ready(cReady), .Ext_MemWrite(cMw), .Ext_DataAdr(cAdr), .Ext_WriteData(cWd),
    .cpu_reset(cCpuRst), .busy(cBusy), .done(cDone), .error(cErr)
  );

  task automatic sendC(input logic [7:0] b);
    int t;
    cValid = 1'b1;
    cData  = b;
    t = 0;
    forever begin
      @(negedge clk);
      if (cReady) break;
      t++;
      if (t > 40) begin
        checks++;
        errors++;
        $display("[TB] FAIL cAcceptTimeout: byte %h not accepted", b);
        cValid = 1'b0;
        return;
      end
    end
    @(posedge clk); #1;
    cValid = 1'b0;
  endtask

  task automatic pulseC();
    cStart = 1'b1;
    @(posedge clk); #1;
    cStart = 1'b0;
  endtask

  task automatic csumLoad(input logic [7:0] trailer);
    pulseC();
    sendC(8'h01); sendC(8'h02); sendC(8'h03); sendC(8'h04);
    sendC(trailer);
  endtask
`endif

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vec_t tbl[$];
    vec_t v;
    reset = 1'b1; start = 1'b0; inValid = 1'b0; inData = 8'h00;
`ifdef LOADER_CHECKSUM_EN
    cStart = 1'b0; cValid = 1'b0; cData = 8'h00;
`endif
    repeat (3) @(posedge clk);
    #1;
    checkOutput("resetA", {aReady, aMw, aAdr, aWd, aCpuRst, aBusy, aDone, aErr},
                {2'b00, 64'd0, 4'b1000});
    checkOutput("resetB", {bReady, bMw, bAdr, bWd, bCpuRst, bBusy, bDone, bErr},
                {2'b00, 64'd0, 4'b1000});
    reset = 1'b0;

    // Cycle-exact vectors for the reference stream with in_valid held high.
    tbl.push_back(mk(1, 0, 8'h00, 1, 0, 32'h0, 32'h0,        32'h0,        1, 1, 0));
    tbl.push_back(mk(0, 1, 8'h78, 1, 0, 32'h0, 32'h0,        32'h0,        1, 1, 0));
    tbl.push_back(mk(0, 1, 8'h56, 1, 0, 32'h0, 32'h0,        32'h0,        1, 1, 0));
    tbl.push_back(mk(0, 1, 8'h34, 1, 0, 32'h0, 32'h0,        32'h0,        1, 1, 0));
    tbl.push_back(mk(0, 1, 8'h12, 0, 1, 32'h0, 32'hFFFFFFFC, 32'h12345678, 1, 1, 0));
    tbl.push_back(mk(0, 1, 8'hEF, 1, 0, 32'h0, 32'hFFFFFFFC, 32'h12345678, 1, 1, 0));
    tbl.push_back(mk(0, 1, 8'hEF, 1, 0, 32'h0, 32'hFFFFFFFC, 32'h12345678, 1, 1, 0));
    tbl.push_back(mk(0, 1, 8'hBE, 1, 0, 32'h0, 32'hFFFFFFFC, 32'h12345678, 1, 1, 0));
    tbl.push_back(mk(0, 1, 8'hAD, 1, 0, 32'h0, 32'hFFFFFFFC, 32'h12345678, 1, 1, 0));
    tbl.push_back(mk(0, 1, 8'hDE, 0, 1, 32'h4, 32'h0,        32'hDEADBEEF, 1, 1, 0));
`ifdef LOADER_CHECKSUM_EN
    tbl.push_back(mk(0, 1, 8'hB4, 1, 0, 32'h4, 32'h0,        32'hDEADBEEF, 1, 1, 0));
    tbl.push_back(mk(0, 1, 8'hB4, 0, 0, 32'h4, 32'h0,        32'hDEADBEEF, 0, 0, 1));
    tbl.push_back(mk(0, 0, 8'h00, 0, 0, 32'h4, 32'h0,        32'hDEADBEEF, 0, 0, 1));
`else
    tbl.push_back(mk(0, 0, 8'h00, 0, 0, 32'h4, 32'h0,        32'hDEADBEEF, 0, 0, 1));
    tbl.push_back(mk(0, 0, 8'h00, 0, 0, 32'h4, 32'h0,        32'hDEADBEEF, 0, 0, 1));
`endif
    for (int i = 0; i < tbl.size(); i++) begin
      v = tbl[i];
      start = v.st; inValid = v.vld; inData = v.dat;
      @(posedge clk); #1;
      checkOutput($sformatf("vecA%0d", i), {aReady, aMw, aAdr, aWd, aCpuRst, aBusy, aDone, aErr},
                  {v.rdy, v.mw, v.adrA, v.wd, v.cr, v.bz, v.dn, 1'b0});
      checkOutput($sformatf("vecB%0d", i), {bReady, bMw, bAdr, bWd, bCpuRst, bBusy, bDone, bErr},
                  {v.rdy, v.mw, v.adrB, v.wd, v.cr, v.bz, v.dn, 1'b0});
    end
    start = 1'b0; inValid = 1'b0;
    monEn = 1'b1;

    // Reload from RUN with the same stream, in_valid toggling.
    sb = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    doStart("reloadFromRun");
    loadStream("toggleLoad", 1);

    // Reset after 6 bytes aborts the load; a fresh load starts at index 0.
    doStart("startBeforeAbort");
    for (int i = 0; i < 6; i++) applyStimulus(8'($urandom), 0, 1'b1);
    reset = 1'b1; inValid = 1'b1; inData = 8'h5A;
    @(posedge clk); #1;
    checkOutput("abortA", {aReady, aMw, aAdr, aWd, aCpuRst, aBusy, aDone, aErr},
                {2'b00, 64'd0, 4'b1000});
    checkOutput("abortB", {bReady, bMw, bAdr, bWd, bCpuRst, bBusy, bDone, bErr},
                {2'b00, 64'd0, 4'b1000});
    reset = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    inValid = 1'b0;
    checkOutput("idleAfterAbort", {aReady, aBusy, aCpuRst, aDone, 32'(expQ.size())},
                {4'b0010, 32'd0});
    for (int i = 0; i < 8; i++) sb[i] = 8'($urandom);
    doStart("startAfterAbort");
    loadStream("loadAfterAbort", 0);

    // Randomized reloads with random gaps.
    for (int n = 0; n < 6; n++) begin
      for (int i = 0; i < 8; i++) sb[i] = 8'($urandom);
      doStart($sformatf("randStart%0d", n));
      loadStream($sformatf("randLoad%0d", n), -1);
    end

`ifdef LOADER_CHECKSUM_EN
    csumLoad(8'hF6);
    checkOutput("csumGood", {cDone, cCpuRst, cErr}, {3'b100});
    csumLoad(8'hF7);
    checkOutput("csumBad", {cDone, cCpuRst, cErr, cReady}, {4'b0110});
    pulseC();
    checkOutput("errClear", {cErr, cBusy, cReady}, {3'b011});
    sendC(8'h01); sendC(8'h02); sendC(8'h03); sendC(8'h04);
    sendC(8'hF6);
    checkOutput("csumRecover", {cDone, cCpuRst, cErr}, {3'b100});
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_loader.md
# mem_loader

Boot-time data-memory loader for the single-cycle RV32IM core top level. It accepts a byte stream over a valid/ready handshake and packs bytes little-endian into 32-bit words. It drives the top level's external write port (Ext_MemWrite / Ext_DataAdr / Ext_WriteData) while holding the core in reset, then releases the core. It is the initiator for the external memory-load path, which the top level only honours while its reset is high.

## Interface
- WORDS, default 64: number of 32-bit words per load; legal range 1..1024.
- BASE_ADDR, default 32'h0000_0000: byte address of the first word; must be word-aligned.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  single-cycle pulse that begins a load.
- in_valid  in  1  byte available on in_data.
- in_data  in  8  stream byte.
- in_ready  out  1  loader can accept a byte this cycle.
- Ext_MemWrite  out  1  write strobe to the top-level external port.
- Ext_DataAdr  out  32  write byte address.
- Ext_WriteData  out  32  write data word.
- cpu_reset  out  1  drives the core/top-level reset input.
- busy  out  1  load in progress.
- done  out  1  load complete; core released.
- error  out  1  checksum failure; see Configuration.

## Operation
- States: IDLE, COLLECT, WRITE, CHECK (present only with the macro), RUN, ERR.
- All outputs are registered or Moore-decoded from the state; there are no combinational paths from inputs to outputs.
- IDLE: cpu_reset=1, in_ready=0. start moves to COLLECT and clears the word index, byte index, and checksum.
- COLLECT: in_ready=1.
  - Each accepted byte (in_valid && in_ready at an edge) is stored into word bits [8*k+7:8*k], where k is the byte index 0..3.
  - The 4th accepted byte moves the FSM to WRITE.
- WRITE: lasts exactly one cycle.
  - Outputs: Ext_MemWrite=1, Ext_DataAdr=BASE_ADDR+4*idx (32-bit, wraps modulo 2^32), Ext_WriteData=assembled word, in_ready=0.
  - Then idx increments. If idx was WORDS-1, go to CHECK (macro) or RUN; otherwise return to COLLECT.
- RUN: cpu_reset=0, done=1, in_ready=0. A start pulse re-enters COLLECT with cpu_reset=1 the following cycle, i.e. a reload.
- busy=1 in COLLECT, WRITE, and CHECK; 0 otherwise.
- cpu_reset=1 in every state except RUN.
- Ext_MemWrite=0 outside WRITE. Ext_DataAdr and Ext_WriteData hold their last values.
- start is ignored in COLLECT, WRITE, and CHECK.
- Bytes presented while in_ready=0 are not consumed. The source must hold them until accepted.
- The loader only issues full-word writes. The top-level data memory must be in word mode during load.

## Timing
- Reset values: in_ready=0, Ext_MemWrite=0, Ext_DataAdr=0, Ext_WriteData=0, cpu_reset=1, busy=0, done=0, error=0. State goes to IDLE; all counters are zeroed.
- Reset asserted mid-load aborts the load on that edge with no further writes. Already-written words remain in memory.
- start at edge T: in_ready=1 from cycle T+1.
- 4th byte accepted at edge N: Ext_MemWrite=1 during cycle N+1 (memory captures at edge N+2), and in_ready=1 again from cycle N+2.
- Peak throughput is one word per 5 cycles.
- Last WRITE at cycle W: done=1 and cpu_reset=0 from cycle W+1 without the macro, or one cycle after the checksum byte is accepted with it.
- The word counter is ceil(log2(WORDS+1)) bits and never exceeds WORDS.

## Configuration
- LOADER_CHECKSUM_EN defined:
  - An 8-bit additive checksum accumulates over all payload bytes.
  - After the last WRITE, the FSM enters CHECK with in_ready=1 and accepts one trailing checksum byte.
  - If (sum + byte) mod 256 == 0, go to RUN. Otherwise go to ERR: error=1, cpu_reset=1, in_ready=0.
  - ERR exits only on start (to COLLECT, clearing error) or reset.
- LOADER_CHECKSUM_EN undefined: CHECK and ERR do not exist, error is tied to 0, and the FSM goes from the last WRITE directly to RUN.

## Test plan
- WORDS=2, BASE_ADDR=0; stream 78 56 34 12 EF BE AD DE with in_valid held high:
  - Ext_MemWrite pulses exactly twice: 0x0/0x12345678, then 0x4/0xDEADBEEF.
  - One cycle after the second write, done=1 and cpu_reset=0.
- Same stream with in_valid toggling every other cycle: identical writes; each write occurs one cycle after its 4th accepted byte; no byte is lost or duplicated.
- BASE_ADDR=32'hFFFF_FFFC, WORDS=2: write addresses are 0xFFFFFFFC, then 0x00000000.
- Reset asserted after 6 bytes: all outputs return to reset values next cycle; no further Ext_MemWrite. A subsequent start plus a full stream loads correctly from index 0.
- With LOADER_CHECKSUM_EN, WORDS=1; bytes 01 02 03 04:
  - trailing byte F6: done=1.
  - trailing byte F7: error=1, cpu_reset stays 1; then start and a correct stream recover to done=1.
- In RUN, pulse start: cpu_reset=1 next cycle, busy=1, done=0; a new stream overwrites memory from BASE_ADDR.
